// File: rtl/sbox_table_gen.sv
// AES S-box table generator: builds sbox[x] = affine(x^254) for all 256 x, then serves lookups.
// Optional macro SBOX_INV_TABLE_EN adds an inverse table written alongside the forward table.
module sbox_table_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       ready,
    input  logic       lookup_valid,
    input  logic       encrypt,
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out,
    output logic       out_valid
);

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DEPTH     = 256;
    localparam int unsigned MUL_STEPS = 13;
    localparam int unsigned STEP_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        WRITE,
        DONE
    } state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [DATA_W-1:0] gf_mul(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] affine(input logic [DATA_W-1:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    state_t              state, state_next;
    logic [DATA_W-1:0]   x, x_next;
    logic [DATA_W-1:0]   r, r_next;
    logic [STEP_W-1:0]   step, step_next;
    logic                busy_next, done_next, ready_next;
    logic                wr_en_c;
    logic [DATA_W-1:0]   wr_data_c;

    logic [DATA_W-1:0]   sbox_mem [DEPTH];
`ifdef SBOX_INV_TABLE_EN
    logic [DATA_W-1:0]   inv_mem  [DEPTH];
`endif

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_next = state;
        x_next     = x;
        r_next     = r;
        step_next  = step;
        wr_en_c    = 1'b0;
        wr_data_c  = affine(r);
        ready_next = ready;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    x_next     = '0;
                    ready_next = 1'b0;
                end
            end
            LOAD: begin
                r_next     = x;
                step_next  = '0;
                state_next = MUL;
            end
            MUL: begin
                // Even steps square, odd steps multiply by x: walks the exponent to 254
                r_next    = gf_mul(r, step[0] ? x : r);
                step_next = step + STEP_W'(1);
                if (step == STEP_W'(MUL_STEPS - 1)) state_next = WRITE;
            end
            WRITE: begin
                wr_en_c = 1'b1;
                if (x != 8'hFF) begin
                    x_next     = x + DATA_W'(1);
                    state_next = LOAD;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == LOAD) || (state_next == MUL) || (state_next == WRITE);
        done_next = (state_next == DONE);
        if (state_next == DONE) ready_next = 1'b1;
    end

    // Control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            r     <= '0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            x     <= x_next;
            r     <= r_next;
            step  <= step_next;
            busy  <= busy_next;
            done  <= done_next;
            ready <= ready_next;
        end
    end

    // Table storage is never cleared; only a complete generation sets ready
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            sbox_mem[x] <= wr_data_c;
`ifdef SBOX_INV_TABLE_EN
            inv_mem[wr_data_c] <= x;
`endif
        end
    end

    // Lookup port: one-cycle latency, dropped while tables are not valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (lookup_valid && ready) begin
                out_valid <= 1'b1;
                if (encrypt) begin
                    byte_out <= sbox_mem[byte_in];
                end else begin
`ifdef SBOX_INV_TABLE_EN
                    byte_out <= inv_mem[byte_in];
`else
                    byte_out <= 8'h00;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_table_gen.sv
// Self-checking bench for sbox_table_gen against a field-arithmetic reference model.
module tb_sbox_table_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, ready;
    logic       lookup_valid;
    logic       encrypt;
    logic [7:0] byte_in;
    logic [7:0] byte_out;
    logic       out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] model_sbox [256];
    logic [7:0] model_inv  [256];
    logic [7:0] last_bo = 8'h00;

    sbox_table_gen dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .ready(ready),
        .lookup_valid(lookup_valid), .encrypt(encrypt), .byte_in(byte_in),
        .byte_out(byte_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int m_mul(input int a, input int b);
        int p = 0;
        int aa = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11B;
        end
        return p;
    endfunction

    function automatic int m_inv(input int a);
        if (a == 0) return 0;
        for (int y = 1; y < 256; y++) if (m_mul(a, y) == 1) return y;
        return -1;
    endfunction

    function automatic logic [7:0] m_affine(input logic [7:0] b);
        logic [7:0] c = 8'h63;
        logic [7:0] s;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [7:0] m_lookup(input bit enc, input logic [7:0] a);
        if (enc) return model_sbox[a];
`ifdef SBOX_INV_TABLE_EN
        return model_inv[a];
`else
        return 8'h00;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; lookup_valid = 1'b0; encrypt = 1'b1; byte_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, ready, out_valid, byte_out} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b ready=%b ov=%b bo=%h, want all 0",
                     busy, done, ready, out_valid, byte_out);
        end
        @(negedge clk); rst = 1'b0;
        lookup_valid = 1'b1; byte_in = 8'h01;
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || byte_out !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_before_ready: got ov=%b bo=%h, want ov=0 bo=00", out_valid, byte_out);
        end
    endtask

    // Start a generation at edge 0 and check status timing cycle by cycle
    task automatic run_gen(input bit hold_lookup, input int restart_cyc, input string name);
        int printed = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lookup_valid = hold_lookup;
        for (int cyc = 1; cyc <= 3842; cyc++) begin
            n_tests++;
            if (busy !== (cyc <= 3840) || done !== (cyc == 3841) || ready !== (cyc >= 3841)) begin
                n_fail++;
                if (printed++ < 10)
                    $display("FAIL %s_status cyc=%0d: got busy=%b done=%b ready=%b, want %b %b %b",
                             name, cyc, busy, done, ready, cyc <= 3840, cyc == 3841, cyc >= 3841);
            end
            n_tests++;
            if (out_valid !== 1'b0 || byte_out !== last_bo) begin
                n_fail++;
                if (printed++ < 10)
                    $display("FAIL %s_lookup_drop cyc=%0d: got ov=%b bo=%h, want ov=0 bo=%h",
                             name, cyc, out_valid, byte_out, last_bo);
            end
            byte_in = 8'($urandom);
            encrypt = 1'($urandom);
            if (cyc >= 3841) lookup_valid = 1'b0;
            start = (restart_cyc != 0 && cyc == restart_cyc);
            @(posedge clk); #1;
        end
        start = 1'b0;
        lookup_valid = 1'b0;
    endtask

    task automatic test_generation();
        run_gen(1'b0, 0, "gen");
    endtask

    task automatic test_known_vectors();
        logic [7:0] addr [4] = '{8'h00, 8'h01, 8'h53, 8'hFF};
        logic [7:0] expv [4] = '{8'h63, 8'h7C, 8'hED, 8'h16};
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                n_tests++;
                if (out_valid !== 1'b1 || byte_out !== expv[i-1]) begin
                    n_fail++;
                    $display("FAIL known_vec %h: got ov=%b bo=%h, want ov=1 bo=%h",
                             addr[i-1], out_valid, byte_out, expv[i-1]);
                end
            end
            if (i < 4) begin
                lookup_valid = 1'b1; encrypt = 1'b1; byte_in = addr[i];
            end else begin
                lookup_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        last_bo = expv[3];
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL known_vec_idle: got ov=%b, want 0", out_valid);
        end
    endtask

    // Back-to-back random lookups with random gaps, covering every forward address once
    task automatic test_random_lookups(input string name);
        bit         e_ov = 1'b0;
        bit         lv;
        bit         enc;
        logic [7:0] a;
        int         printed = 0;
        int         n = 600;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                n_tests++;
                if (out_valid !== e_ov || byte_out !== last_bo) begin
                    n_fail++;
                    if (printed++ < 10)
                        $display("FAIL %s i=%0d: got ov=%b bo=%h, want ov=%b bo=%h",
                                 name, i, out_valid, byte_out, e_ov, last_bo);
                end
            end
            if (i < 256) begin
                lv = 1'b1; enc = 1'b1; a = 8'(i);
            end else begin
                lv = ($urandom_range(3) != 0); enc = 1'($urandom); a = 8'($urandom);
            end
            if (i == n) lv = 1'b0;
            lookup_valid = lv; encrypt = enc; byte_in = a;
            e_ov = lv;
            if (lv) last_bo = m_lookup(enc, a);
            @(posedge clk); #1;
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_inverse();
`ifdef SBOX_INV_TABLE_EN
        logic [7:0] addr [3] = '{8'h63, 8'hED, 8'h16};
        logic [7:0] expv [3] = '{8'h00, 8'h53, 8'hFF};
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                n_tests++;
                if (out_valid !== 1'b1 || byte_out !== expv[i-1]) begin
                    n_fail++;
                    $display("FAIL inv_vec %h: got ov=%b bo=%h, want ov=1 bo=%h",
                             addr[i-1], out_valid, byte_out, expv[i-1]);
                end
            end
            lookup_valid = (i < 3); encrypt = 1'b0;
            if (i < 3) byte_in = addr[i];
            @(posedge clk); #1;
        end
        for (int x = 0; x <= 256; x++) begin
            if (x > 0) begin
                n_tests++;
                if (out_valid !== 1'b1 || byte_out !== 8'(x - 1)) begin
                    n_fail++;
                    $display("FAIL inv_sweep x=%0d: got ov=%b bo=%h, want ov=1 bo=%h",
                             x - 1, out_valid, byte_out, 8'(x - 1));
                end
            end
            lookup_valid = (x < 256); encrypt = 1'b0;
            if (x < 256) byte_in = model_sbox[x];
            @(posedge clk); #1;
        end
        last_bo = 8'hFF;
`else
        lookup_valid = 1'b1; encrypt = 1'b0; byte_in = 8'h63;
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || byte_out !== 8'h00) begin
            n_fail++;
            $display("FAIL no_inv_lookup: got ov=%b bo=%h, want ov=1 bo=00", out_valid, byte_out);
        end
        last_bo = 8'h00;
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_busy_ignores();
        run_gen(1'b1, 100, "busy");
    endtask

    task automatic test_reset_abort();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: got busy=%b at cycle 2000, want 1", busy);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_rst: got busy=%b ready=%b ov=%b done=%b, want all 0",
                     busy, ready, out_valid, done);
        end
        @(negedge clk); rst = 1'b0;
        last_bo = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got ready=%b busy=%b, want 0 0", ready, busy);
        end
        run_gen(1'b0, 0, "regen");
    endtask

    initial begin
        for (int x = 0; x < 256; x++) begin
            model_sbox[x] = m_affine(8'(m_inv(x)));
            model_inv[model_sbox[x]] = 8'(x);
        end
        test_reset();
        test_generation();
        test_known_vectors();
        test_random_lookups("rand_lookup");
        test_inverse();
        test_busy_ignores();
        test_known_vectors();
        test_reset_abort();
        test_random_lookups("rand_after_abort");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
